// File: rtl/dkong3_audio_mix.sv
// Mixes the two sub-CPU APU streams, removes DC with a one-pole high-pass and
// box-car decimates down to the output sample rate with a one-clock valid strobe.
module dkong3_audio_mix #(
    parameter int DECIM_LOG2 = 5,
    parameter int DCB_EN     = 1,
    parameter int DCB_SHIFT  = 10
) (
    input  logic        I_SUBCLK,
    input  logic        I_RESET,
    input  logic        I_CPU_CE,
    input  logic [15:0] I_SAMPLE_A,
    input  logic [15:0] I_SAMPLE_B,
    input  logic        I_MUTE,
    output logic [15:0] O_SAMPLE,
    output logic        O_SAMPLE_VALID
);
    localparam int YW = 18 + DCB_SHIFT;
    localparam int AW = 16 + DECIM_LOG2;

    // Stage 1: saturating mix
    logic [16:0] w_sum;
    logic [15:0] w_mix;
    logic [15:0] r_m;
    logic        r_v1;

    assign w_sum = {I_SAMPLE_A[15], I_SAMPLE_A} + {I_SAMPLE_B[15], I_SAMPLE_B};
    assign w_mix = (w_sum[16] != w_sum[15]) ? (w_sum[16] ? 16'h8000 : 16'h7FFF) : w_sum[15:0];

    always_ff @(posedge I_SUBCLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_m  <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= I_CPU_CE;
            if (I_CPU_CE)
                r_m <= I_MUTE ? 16'h0000 : w_mix;
        end
    end

    // Stage 2: DC blocker, y carries DCB_SHIFT fractional bits
    logic signed [16:0]    w_diff;
    logic signed [YW-1:0]  w_dsh;
    logic signed [YW-1:0]  w_y_nxt;
    logic signed [17:0]    w_yq;
    logic        [15:0]    w_ysat;
    logic        [15:0]    w_d;
    logic signed [YW-1:0]  r_y;
    logic        [15:0]    r_xp;
    logic        [15:0]    r_d;
    logic                  r_v2;

    assign w_diff  = $signed({r_m[15], r_m}) - $signed({r_xp[15], r_xp});
    assign w_dsh   = $signed({{(YW-17){w_diff[16]}}, w_diff}) <<< DCB_SHIFT;
    assign w_y_nxt = r_y + w_dsh - (r_y >>> DCB_SHIFT);
    assign w_yq    = w_y_nxt[YW-1:DCB_SHIFT];
    assign w_ysat  = (w_yq[17:15] == 3'b000 || w_yq[17:15] == 3'b111) ? w_yq[15:0]
                   : (w_yq[17] ? 16'h8000 : 16'h7FFF);
    assign w_d     = (DCB_EN != 0) ? w_ysat : r_m;

    always_ff @(posedge I_SUBCLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_y  <= '0;
            r_xp <= '0;
            r_d  <= '0;
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_d <= w_d;
                // Bypass keeps y and xp parked at zero so re-enabling starts clean
                if (DCB_EN != 0) begin
                    r_y  <= w_y_nxt;
                    r_xp <= r_m;
                end
            end
        end
    end

    // Stage 3: box-car decimator
    logic [AW-1:0]         w_acc_sum;
    logic [AW-1:0]         r_acc;
    logic [DECIM_LOG2-1:0] r_cnt;
    logic [15:0]           r_out;
    logic                  r_valid;

    assign w_acc_sum = r_acc + {{DECIM_LOG2{r_d[15]}}, r_d};

    always_ff @(posedge I_SUBCLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_v2) begin
                if (&r_cnt) begin
                    // Top 16 bits of the full-window sum are the floor average
                    r_out   <= w_acc_sum[AW-1 -: 16];
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_valid <= 1'b1;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign O_SAMPLE       = r_out;
    assign O_SAMPLE_VALID = r_valid;
endmodule

// File: tb/tb_dkong3_audio_mix.sv
// Bench for dkong3_audio_mix: one instance with the DC blocker bypassed and one
// with it enabled, both checked against an arithmetic model of mix/filter/average.
module tb_dkong3_audio_mix;
    localparam int L = 5;
    localparam int K = 10;
    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] o0, o1;
    logic        v0, v1;

    int vectors = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dkong3_audio_mix #(.DECIM_LOG2(L), .DCB_EN(0), .DCB_SHIFT(K)) u_dut0 (
        .I_SUBCLK(clk), .I_RESET(rst), .I_CPU_CE(ce), .I_SAMPLE_A(a), .I_SAMPLE_B(b),
        .I_MUTE(mute), .O_SAMPLE(o0), .O_SAMPLE_VALID(v0));

    dkong3_audio_mix #(.DECIM_LOG2(L), .DCB_EN(1), .DCB_SHIFT(K)) u_dut1 (
        .I_SUBCLK(clk), .I_RESET(rst), .I_CPU_CE(ce), .I_SAMPLE_A(a), .I_SAMPLE_B(b),
        .I_MUTE(mute), .O_SAMPLE(o1), .O_SAMPLE_VALID(v1));

    // Reference model state
    longint      m_y, m_xp, m_sum0, m_sum1;
    int          m_cnt;
    logic [15:0] m_out0, m_out1;
    bit          m_dump;

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        m_y = 0; m_xp = 0; m_sum0 = 0; m_sum1 = 0; m_cnt = 0;
        m_out0 = '0; m_out1 = '0; m_dump = 0;
    endtask

    task automatic model_step(input logic [15:0] sa, input logic [15:0] sb, input logic mu);
        longint x, d1;
        x = sat16(longint'($signed(sa)) + longint'($signed(sb)));
        if (mu) x = 0;
        m_y  = m_y + (x - m_xp) * 1024 - (m_y >>> K);
        m_xp = x;
        d1   = sat16(m_y >>> K);
        m_sum0 += x;
        m_sum1 += d1;
        m_cnt++;
        m_dump = 0;
        if (m_cnt == N) begin
            m_out0 = 16'(m_sum0 >>> L);
            m_out1 = 16'(m_sum1 >>> L);
            m_sum0 = 0; m_sum1 = 0; m_cnt = 0; m_dump = 1;
        end
    endtask

    // Called at a negedge; drives one CE and watches 'gap' following negedges.
    task automatic ce_pulse(input logic [15:0] sa, input logic [15:0] sb, input logic mu,
                            input int gap, output logic [15:0] vv0, output logic [15:0] vv1,
                            output logic [15:0] pre0, output logic [15:0] pre1,
                            output logic [15:0] post0, output logic [15:0] post1);
        a = sa; b = sb; mute = mu; ce = 1'b1;
        vv0 = '0; vv1 = '0; pre0 = '0; pre1 = '0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            ce = 1'b0;
            vv0[i] = v0;
            vv1[i] = v1;
            if (i == 0) begin pre0 = o0; pre1 = o1; end
        end
        post0 = o0; post1 = o1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [15:0] vv0, vv1, p0, p1, s0, s1;
        vectors++;
        if ({o0, v0} !== 17'h0) begin errs++; $display("FAIL reset_por dut0 got %h/%b exp 0000/0", o0, v0); end
        vectors++;
        if ({o1, v1} !== 17'h0) begin errs++; $display("FAIL reset_por dut1 got %h/%b exp 0000/0", o1, v1); end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            model_step(16'h1000, 16'h0000, 1'b0);
            ce_pulse(16'h1000, 16'h0000, 1'b0, 3, vv0, vv1, p0, p1, s0, s1);
            vectors++;
            if (vv0 !== (m_dump ? 16'h0004 : 16'h0000)) begin
                errs++; $display("FAIL reset_pre vld ce%0d got %h exp %h", i, vv0, m_dump ? 16'h0004 : 16'h0000);
            end
        end
        vectors++;
        if (o0 !== 16'h1000) begin errs++; $display("FAIL reset_pre sample got %h exp 1000", o0); end
        // Assert reset between edges while the strobe is high
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({o0, v0, o1, v1} !== 34'h0) begin
            errs++; $display("FAIL reset_async got %h/%b %h/%b exp all zero", o0, v0, o1, v1);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            model_step(16'h0800, 16'h0800, 1'b0);
            ce_pulse(16'h0800, 16'h0800, 1'b0, 3, vv0, vv1, p0, p1, s0, s1);
            vectors++;
            if (vv0 !== (m_dump ? 16'h0004 : 16'h0000)) begin
                errs++; $display("FAIL reset_post vld ce%0d got %h exp %h", i, vv0, m_dump ? 16'h0004 : 16'h0000);
            end
            vectors++;
            if (vv1 !== vv0 || s1 !== m_out1) begin
                errs++; $display("FAIL reset_post dut1 ce%0d got %h/%h exp %h/%h", i, vv1, s1, vv0, m_out1);
            end
        end
        vectors++;
        if (s0 !== 16'h1000) begin errs++; $display("FAIL reset_post sample got %h exp 1000", s0); end
    endtask

    task automatic test_static();
        logic [15:0] vv0, vv1, p0, p1, s0, s1;
        for (int i = 0; i < 2 * N; i++) begin
            model_step(16'h1000, 16'h2000, 1'b0);
            ce_pulse(16'h1000, 16'h2000, 1'b0, 12, vv0, vv1, p0, p1, s0, s1);
            vectors++;
            if (vv0 !== (m_dump ? 16'h0004 : 16'h0000)) begin
                errs++; $display("FAIL static vld ce%0d got %h exp %h", i, vv0, m_dump ? 16'h0004 : 16'h0000);
            end
            if (m_dump) begin
                vectors++;
                if (s0 !== 16'h3000) begin errs++; $display("FAIL static sample ce%0d got %h exp 3000", i, s0); end
            end
        end
    endtask

    task automatic test_sat();
        logic [15:0] vv0, vv1, p0, p1, s0, s1;
        logic [15:0] ta [3];
        logic [15:0] tbv [3];
        logic [15:0] te [3];
        ta  = '{16'h7FFF, 16'h8000, 16'h7FFF};
        tbv = '{16'h7FFF, 16'h8000, 16'h8001};
        te  = '{16'h7FFF, 16'h8000, 16'h0000};
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) begin
                model_step(ta[c], tbv[c], 1'b0);
                ce_pulse(ta[c], tbv[c], 1'b0, 3, vv0, vv1, p0, p1, s0, s1);
            end
            vectors++;
            if (vv0 !== 16'h0004) begin errs++; $display("FAIL sat%0d vld got %h exp 0004", c, vv0); end
            vectors++;
            if (s0 !== te[c] || s0 !== m_out0) begin
                errs++; $display("FAIL sat%0d sample got %h exp %h", c, s0, te[c]);
            end
        end
    endtask

    task automatic test_dc();
        logic [15:0] vv0, vv1, p0, p1, s0, s1;
        int prev, first_pos, first_neg, win;
        apply_reset();
        prev = 32767; first_pos = 0; first_neg = 0; win = 0;
        for (int i = 0; i < 20000; i++) begin
            model_step(16'h4000, 16'h0000, 1'b0);
            ce_pulse(16'h4000, 16'h0000, 1'b0, 3, vv0, vv1, p0, p1, s0, s1);
            if (m_dump) begin
                vectors++;
                if (s1 !== m_out1) begin errs++; $display("FAIL dc_step model win%0d got %h exp %h", win, s1, m_out1); end
                if (win == 0) begin
                    first_pos = int'($signed(s1));
                    vectors++;
                    if (first_pos <= 32'sh3C00) begin errs++; $display("FAIL dc_first got %h exp >3c00", s1); end
                end
                vectors++;
                if (int'($signed(s1)) > prev) begin
                    errs++; $display("FAIL dc_monotonic win%0d got %0d exp <=%0d", win, $signed(s1), prev);
                end
                prev = int'($signed(s1));
                win++;
            end
        end
        vectors++;
        if (prev > 4 || prev < -4) begin errs++; $display("FAIL dc_settle got %0d exp within +-4", prev); end
        for (int i = 0; i < 2 * N; i++) begin
            model_step(16'h0000, 16'h0000, 1'b0);
            ce_pulse(16'h0000, 16'h0000, 1'b0, 3, vv0, vv1, p0, p1, s0, s1);
            if (m_dump) begin
                vectors++;
                if (s1 !== m_out1) begin errs++; $display("FAIL dc_neg model ce%0d got %h exp %h", i, s1, m_out1); end
                if (i == N - 1) first_neg = int'($signed(s1));
            end
        end
        vectors++;
        if (first_neg >= -32'sh3C00 || first_neg + first_pos > 4 || first_neg + first_pos < -4) begin
            errs++; $display("FAIL dc_symmetry got %0d exp about -%0d", first_neg, first_pos);
        end
    endtask

    task automatic test_mute();
        logic [15:0] vv0, vv1, p0, p1, s0, s1;
        apply_reset();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < N; i++) begin
                model_step(16'h1000, 16'h1000, (w == 0 && i < 16));
                ce_pulse(16'h1000, 16'h1000, (w == 0 && i < 16), 3, vv0, vv1, p0, p1, s0, s1);
            end
            vectors++;
            if (vv0 !== 16'h0004 || s0 !== (w == 0 ? 16'h1000 : 16'h2000) || s0 !== m_out0) begin
                errs++; $display("FAIL mute win%0d got %h/%h exp 0004/%h", w, vv0, s0, w == 0 ? 16'h1000 : 16'h2000);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] vv0, vv1, p0, p1, s0, s1;
        apply_reset();
        for (int i = 0; i <= 20; i++)
            ce_pulse(16'h7000, 16'h0000, 1'b0, 3, vv0, vv1, p0, p1, s0, s1);
        apply_reset();
        for (int i = 0; i < N; i++) begin
            model_step(16'h0100, 16'h0000, 1'b0);
            ce_pulse(16'h0100, 16'h0000, 1'b0, 3, vv0, vv1, p0, p1, s0, s1);
            vectors++;
            if (vv0 !== (i == N - 1 ? 16'h0004 : 16'h0000)) begin
                errs++; $display("FAIL reset_mid vld ce%0d got %h exp %h", i, vv0, i == N - 1 ? 16'h0004 : 16'h0000);
            end
        end
        vectors++;
        if (s0 !== 16'h0100) begin errs++; $display("FAIL reset_mid sample got %h exp 0100", s0); end
    endtask

    task automatic test_random();
        logic [15:0] vv0, vv1, p0, p1, s0, s1, ra, rb, e0, e1, ev;
        logic        rm;
        int          gap;
        for (int i = 0; i < 4 * N; i++) begin
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            rm  = ($urandom_range(0, 7) == 0);
            gap = $urandom_range(3, 7);
            e0 = m_out0; e1 = m_out1;
            model_step(ra, rb, rm);
            ev = m_dump ? 16'h0004 : 16'h0000;
            ce_pulse(ra, rb, rm, gap, vv0, vv1, p0, p1, s0, s1);
            vectors++;
            if (vv0 !== ev || vv1 !== ev) begin
                errs++; $display("FAIL rand vld ce%0d got %h/%h exp %h", i, vv0, vv1, ev);
            end
            vectors++;
            if (p0 !== e0 || p1 !== e1) begin
                errs++; $display("FAIL rand hold ce%0d got %h/%h exp %h/%h", i, p0, p1, e0, e1);
            end
            vectors++;
            if (s0 !== m_out0 || s1 !== m_out1) begin
                errs++; $display("FAIL rand sample ce%0d got %h/%h exp %h/%h", i, s0, s1, m_out0, m_out1);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_static();
        test_sat();
        test_mute();
        test_reset_mid();
        test_random();
        test_dc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
